alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  4  opcode: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 INC, 10 DEC, 11 CMP, 12-15 PASS.
REQ-005 SHALL have ports a and b  input  8 each  operands.
REQ-006 SHALL have port carry_in  input  1  current carry flag.
REQ-007 SHALL have port decimal_flag  input  1  current decimal-mode flag.
REQ-008 SHALL have port result  output  8  registered result; feeds the status register data_in.
REQ-009 SHALL have port carry_out  output  1  registered carry; feeds the status register carry_in.
REQ-010 SHALL have port overflow_out  output  1  registered overflow; feeds the status register overflow_in.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when result, carry_out and overflow_out are final.

Function
REQ-013 SHALL implement states IDLE, EXEC, ADJUST and DONE.
REQ-014 SHALL move IDLE->EXEC when start=1, latching op, a, b, carry_in and decimal_flag; start in any other state SHALL be ignored.
REQ-015 SHALL, in EXEC, register the binary result, carry_out and overflow_out, then go to ADJUST if the op is ADC/SBC with the latched decimal_flag=1 and decimal support is compiled in, otherwise to DONE.
REQ-016 SHALL, in ADJUST, overwrite result and carry_out with the BCD-corrected values, keep overflow_out from EXEC, and go to DONE.
REQ-017 SHALL drive done=1 for exactly the DONE cycle, then return to IDLE.
REQ-018 SHALL give latency start->done of 2 cycles for binary ops and 3 cycles for decimal ops.
REQ-019 SHALL hold result, carry_out and overflow_out stable from DONE until the next EXEC write.
REQ-020 ADC SHALL compute r=a+b+c as 9 bits; carry_out=r[8]; overflow_out=(a[7]==b[7])&&(r[7]!=a[7]).
REQ-021 SBC SHALL be ADC with b replaced by ~b.
REQ-022 CMP SHALL compute result=a-b (8 bits), with carry_out=(a>=b unsigned) and overflow_out=0.
REQ-023 AND, ORA and EOR SHALL compute the bitwise result of a and b, with carry_out=carry_in and overflow_out=0.
REQ-024 For ASL, LSR, ROL and ROR on a, the shifted-out bit SHALL go to carry_out, ROL/ROR SHALL shift carry_in in, and overflow_out SHALL be 0.
REQ-025 INC and DEC SHALL compute a±1 mod 256 (0xFF+1=0x00, 0x00-1=0xFF), with carry_out=carry_in and overflow_out=0.
REQ-026 PASS SHALL give result=a, carry_out=carry_in and overflow_out=0.
REQ-027 Decimal ADC SHALL compute: lo=a[3:0]+b[3:0]+c, add 6 if lo>9; hi=a[7:4]+b[7:4]+(lo>15), add 6 if hi>9; carry_out=(hi>15); result={hi[3:0],lo[3:0]}.
REQ-028 Decimal SBC SHALL subtract 6 from the low nibble if a[3:0]-b[3:0]-!c<0, subtract 0x60 if the binary borrow is set (carry=0), and keep carry_out=binary carry.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, force state=IDLE, result=0x00, carry_out=0, overflow_out=0, busy=0 and done=0, overriding start.
REQ-030 SHALL abort any operation if reset is asserted mid-operation, with no done pulse for it.

Configuration
REQ-031 SHALL, with macro ALU_DECIMAL_EN defined, implement ADJUST and decimal ADC/SBC per REQ-027/028.
REQ-032 SHALL, without ALU_DECIMAL_EN, omit ADJUST, ignore decimal_flag, and compute ADC/SBC in binary with 2-cycle latency.

Verification
REQ-033 Bench SHALL check binary ADC a=0x50 b=0x50 c=0 -> result 0x A0, carry 0, overflow 1, done 2 cycles after start.
REQ-034 Bench SHALL check decimal ADC (ALU_DECIMAL_EN defined) a=0x99 b=0x01 c=0 -> result 0x00, carry 1, done 3 cycles after start.
REQ-035 Bench SHALL check decimal SBC a=0x10 b=0x01 c=1 -> result 0x09, carry 1; and the same SBC without ALU_DECIMAL_EN -> result 0x0F, carry 1, 2 cycles.
REQ-036 Bench SHALL check CMP a=0x40 b=0x40 -> result 0x00, carry 1, overflow 0; and ROR a=0x01 c=1 -> result 0x80, carry 1.
REQ-037 Bench SHALL pulse start again while busy=1 -> ignored, with exactly one done pulse.
REQ-038 Bench SHALL assert reset during EXEC -> next cycle IDLE, result 0x00, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle 6502-style ALU sequencer: IDLE -> EXEC -> (ADJUST) -> DONE.
// Decimal-mode ADC/SBC correction is compiled in only when ALU_DECIMAL_EN is defined.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic       decimal_flag,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       overflow_out,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2,  OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4,  OP_ASL = 4'd5,  OP_LSR = 4'd6,  OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_CMP = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, ADJUST, DONE} state_t;

  state_t     state_reg;
  logic [3:0] op_reg;
  logic [7:0] a_reg, b_reg;
  logic       c_reg;
  logic [7:0] result_reg;
  logic       carry_reg, overflow_reg, busy_reg, done_reg;

  logic [7:0] bin_result_next;
  logic       bin_carry_next, bin_overflow_next;
  logic [7:0] b_eff;
  logic [8:0] sum9, diff9;

  assign result       = result_reg;
  assign carry_out    = carry_reg;
  assign overflow_out = overflow_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

  always_comb begin
    b_eff             = (op_reg == OP_SBC) ? ~b_reg : b_reg;
    sum9              = {1'b0, a_reg} + {1'b0, b_eff} + {8'd0, c_reg};
    diff9             = {1'b0, a_reg} - {1'b0, b_reg};
    bin_result_next   = a_reg;
    bin_carry_next    = c_reg;
    bin_overflow_next = 1'b0;
    case (op_reg)
      OP_ADC, OP_SBC: begin
        bin_result_next   = sum9[7:0];
        bin_carry_next    = sum9[8];
        bin_overflow_next = (a_reg[7] == b_eff[7]) && (sum9[7] != a_reg[7]);
      end
      OP_AND: bin_result_next = a_reg & b_reg;
      OP_ORA: bin_result_next = a_reg | b_reg;
      OP_EOR: bin_result_next = a_reg ^ b_reg;
      OP_ASL: {bin_carry_next, bin_result_next} = {a_reg, 1'b0};
      OP_LSR: {bin_result_next, bin_carry_next} = {1'b0, a_reg};
      OP_ROL: {bin_carry_next, bin_result_next} = {a_reg, c_reg};
      OP_ROR: {bin_result_next, bin_carry_next} = {c_reg, a_reg};
      OP_INC: bin_result_next = a_reg + 8'd1;
      OP_DEC: bin_result_next = a_reg - 8'd1;
      OP_CMP: begin
        bin_result_next = diff9[7:0];
        bin_carry_next  = ~diff9[8];
      end
      default: ;
    endcase
  end

`ifdef ALU_DECIMAL_EN
  logic       dec_reg;
  logic [7:0] dec_result_next;
  logic       dec_carry_next;
  logic [5:0] lo6, hi6, lo_diff;

  // SBC correction works on the binary result already registered in EXEC.
  always_comb begin
    lo6 = {2'd0, a_reg[3:0]} + {2'd0, b_reg[3:0]} + {5'd0, c_reg};
    if (lo6 > 6'd9) lo6 = lo6 + 6'd6;
    hi6 = {2'd0, a_reg[7:4]} + {2'd0, b_reg[7:4]} + {5'd0, (lo6 > 6'd15)};
    if (hi6 > 6'd9) hi6 = hi6 + 6'd6;
    lo_diff = {2'd0, a_reg[3:0]} - {2'd0, b_reg[3:0]} - {5'd0, ~c_reg};
    if (op_reg == OP_ADC) begin
      dec_result_next = {hi6[3:0], lo6[3:0]};
      dec_carry_next  = (hi6 > 6'd15);
    end else begin
      dec_result_next[3:0] = result_reg[3:0] - (lo_diff[5] ? 4'd6 : 4'd0);
      dec_result_next[7:4] = result_reg[7:4] - (carry_reg ? 4'd0 : 4'd6);
      dec_carry_next       = carry_reg;
    end
  end
`else
  logic unused_decimal;
  assign unused_decimal = decimal_flag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= 4'd0;
      a_reg        <= 8'd0;
      b_reg        <= 8'd0;
      c_reg        <= 1'b0;
      result_reg   <= 8'd0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef ALU_DECIMAL_EN
      dec_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            op_reg    <= op;
            a_reg     <= a;
            b_reg     <= b;
            c_reg     <= carry_in;
`ifdef ALU_DECIMAL_EN
            dec_reg   <= decimal_flag;
`endif
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg   <= bin_result_next;
          carry_reg    <= bin_carry_next;
          overflow_reg <= bin_overflow_next;
`ifdef ALU_DECIMAL_EN
          if (dec_reg && (op_reg == OP_ADC || op_reg == OP_SBC)) begin
            state_reg <= ADJUST;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
`else
          state_reg <= DONE;
          done_reg  <= 1'b1;
`endif
        end
`ifdef ALU_DECIMAL_EN
        ADJUST: begin
          result_reg <= dec_result_next;
          carry_reg  <= dec_carry_next;
          state_reg  <= DONE;
          done_reg   <= 1'b1;
        end
`endif
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
